tt_window_scheduler: RTL
========================

Name: tt_window_scheduler

Overview:
Drives the receive-window checker's table-write interface from a small cyclic schedule of TT flows. Holds up to ENTRIES programmed flow slots (port, buffer, flow id, length, window offsets). Walks them in order against global time and loads each window into the checker ahead of its start. Tracks flag clear, misses, and per-cycle base-time advance.

Parameters:
ENTRIES, 8, number of schedule slots (power of two)
AW, 3, slot index width, log2(ENTRIES)
LEAD, 16, cycles before window start at which the entry is loaded into the checker

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
cfg_wr  in  1  write slot cfg_addr with cfg_* fields
cfg_addr  in  AW  slot index
cfg_port  in  16  egress port number
cfg_buffer  in  16  buffer number
cfg_flow_id  in  16  flow id
cfg_tt_length  in  16  frame length
cfg_off_start  in  32  window start offset from cycle base
cfg_off_end  in  32  window end offset from cycle base
cfg_num  in  AW+1  active slot count, 0..ENTRIES
cfg_period  in  32  schedule cycle length
cfg_base  in  64  first cycle base time, sampled on sched_en rising
sched_en  in  1  run enable
in_global_time  in  64  global time
in_table_rdy  in  1  checker ready for a table write
in_tt_flag_clear  in  1  checker reports current window's frame done
out_table_wr  out  1  one-cycle table write strobe
out_port_number  out  16  to checker
out_buffer_number  out  16  to checker
out_window_start  out  64  base+off_start
out_window_end  out  64  base+off_end
out_flow_id  out  16  to checker
out_tt_length  out  16  to checker
out_tt_flag  out  1  high while loaded window pending
out_cur_entry  out  AW  slot being served
out_miss_cnt  out  16  saturating missed-window count
out_busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; base, index, miss_cnt cleared; slot memory contents don't care.
- cfg_wr accepted in any state, single cycle. Slot fields latched into output registers only at ISSUE, so edits affect a slot's next use.
- States: IDLE, WAIT_RDY, WAIT_LEAD, ISSUE, ACTIVE, ADVANCE.
- IDLE -> WAIT_RDY when sched_en=1 and cfg_num!=0. On that edge: base<=cfg_base, index<=0.
- WAIT_RDY: compute S=base+off_start and E=base+off_end, 64-bit modular adds of zero-extended offsets.
  - If in_global_time > E: miss_cnt++ (saturate at FFFF), go to ADVANCE, no write.
  - Else if in_table_rdy=1: go to WAIT_LEAD.
- WAIT_LEAD: when in_global_time+LEAD >= S, go to ISSUE. The same late check as WAIT_RDY applies here.
- ISSUE: exactly one cycle.
  - out_table_wr=1 with all out_* fields valid that cycle.
  - out_tt_flag<=1; go to ACTIVE.
  - Data fields hold until the next ISSUE.
- ACTIVE: exits to ADVANCE and clears out_tt_flag on either event:
  - in_tt_flag_clear=1: served, no miss.
  - in_global_time > out_window_end with no clear: miss_cnt++.
  - Both in same cycle: served, no miss.
- ADVANCE: one cycle.
  - If index==cfg_num-1: index<=0, base<=base+cfg_period.
  - Else index++.
  - Go to WAIT_RDY.
- sched_en=0 in any state: next edge goes to IDLE; out_tt_flag and out_table_wr are 0 from that edge. Already-issued checker table content is left as is.
- cfg_num changed while running: takes effect at next ADVANCE. If index >= new cfg_num, wrap as end-of-list.
- Latency: sched_en high to first out_table_wr is at least 3 cycles (IDLE, WAIT_RDY, WAIT_LEAD, ISSUE).
- out_cur_entry=index; out_busy=(state!=IDLE).

Decomposition:
- Package tt_sched_pkg: state encoding constants, field widths (16-bit id/port/length, 64-bit time), default LEAD.
- Sub-module tt_sched_table: ENTRIES-deep register file, one write port and one async read port. Controller FSM and time compare stay in the top.

Test Plan:
- Setup: cfg_num=2, base=1000, period=200, slot0 off 16/80, slot1 off 100/150, LEAD=16; time from 990, rdy=1, clear pulsed 20 cycles after each write.
  - Expect out_table_wr at time 1000 (start 1016/end 1080), then at 1084 (1100/1150).
  - Then at 1200 (1216/1280), base advanced; miss_cnt=0.
- Start slot0 with global time already 1090 -> no out_table_wr for slot0, miss_cnt=1, next write is slot1.
- Never pulse clear -> out_tt_flag high from ISSUE until time 1081, then drops; miss_cnt=1; next slot issued.
- Clear and window-end in the same cycle -> miss_cnt unchanged.
- Hold in_table_rdy=0 for 50 cycles -> stays WAIT_RDY with no write; rdy=1 then gives a write after the LEAD condition.
- Deassert sched_en mid-ACTIVE -> IDLE next edge, out_tt_flag=0.
- rst_n=0 mid-run -> all outputs 0 next edge.
- cfg_num=0 with sched_en=1 -> out_busy stays 0.

Source files
------------

// File: rtl/tt_sched_pkg.sv
// Shared types and constants for the TT window scheduler: state encoding,
// field widths and the packed schedule-slot payload.
package tt_sched_pkg;

  localparam int unsigned ID_W         = 16;
  localparam int unsigned OFF_W        = 32;
  localparam int unsigned TIME_W       = 64;
  localparam int unsigned LEAD_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RDY  = 3'd1,
    ST_WAIT_LEAD = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_ACTIVE    = 3'd4,
    ST_ADVANCE   = 3'd5
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]  port;
    logic [ID_W-1:0]  buffer;
    logic [ID_W-1:0]  flow_id;
    logic [ID_W-1:0]  tt_length;
    logic [OFF_W-1:0] off_start;
    logic [OFF_W-1:0] off_end;
  } slot_t;

  // Saturating increment for the miss counter.
  function automatic logic [ID_W-1:0] sat_inc(input logic [ID_W-1:0] v);
    return (v == {ID_W{1'b1}}) ? v : v + ID_W'(1);
  endfunction

endpackage

// File: rtl/tt_sched_table.sv
// Schedule slot register file: one synchronous write port, one async read port.
module tt_sched_table
  import tt_sched_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned AW      = 3
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  slot_t         wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output slot_t         rd_data_c
);

  slot_t mem_q [ENTRIES];

  // Contents are intentionally not reset; slots are reprogrammed before use.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/tt_window_scheduler.sv
// Walks a cyclic schedule of TT flow slots against global time and loads each
// receive window into the checker table ahead of its start.
module tt_window_scheduler
  import tt_sched_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned LEAD    = LEAD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_wr,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_port,
  input  logic [15:0]   cfg_buffer,
  input  logic [15:0]   cfg_flow_id,
  input  logic [15:0]   cfg_tt_length,
  input  logic [31:0]   cfg_off_start,
  input  logic [31:0]   cfg_off_end,
  input  logic [AW:0]   cfg_num,
  input  logic [31:0]   cfg_period,
  input  logic [63:0]   cfg_base,
  input  logic          sched_en,
  input  logic [63:0]   in_global_time,
  input  logic          in_table_rdy,
  input  logic          in_tt_flag_clear,
  output logic          out_table_wr,
  output logic [15:0]   out_port_number,
  output logic [15:0]   out_buffer_number,
  output logic [63:0]   out_window_start,
  output logic [63:0]   out_window_end,
  output logic [15:0]   out_flow_id,
  output logic [15:0]   out_tt_length,
  output logic          out_tt_flag,
  output logic [AW-1:0] out_cur_entry,
  output logic [15:0]   out_miss_cnt,
  output logic          out_busy
);

  state_e state_q, state_d;
  logic [63:0]   base_q, base_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   miss_q, miss_d;
  logic          wr_q, wr_d;
  logic          flag_q, flag_d;
  logic          busy_q, busy_d;
  logic [15:0]   port_q, port_d, buf_q, buf_d, flow_q, flow_d, len_q, len_d;
  logic [63:0]   ws_q, ws_d, we_q, we_d;

  slot_t cfg_slot, slot;
  logic [63:0] win_s, win_e;
  logic late, lead_ok, act_late, last;

  assign cfg_slot = '{port: cfg_port, buffer: cfg_buffer, flow_id: cfg_flow_id,
                      tt_length: cfg_tt_length, off_start: cfg_off_start,
                      off_end: cfg_off_end};

  tt_sched_table #(.ENTRIES(ENTRIES), .AW(AW)) u_table (
    .clk       (clk),
    .wr_en_i   (cfg_wr),
    .wr_addr_i (cfg_addr),
    .wr_data_i (cfg_slot),
    .rd_addr_i (idx_q),
    .rd_data_c (slot)
  );

  // Window of the slot currently indexed, relative to the running cycle base.
  assign win_s    = base_q + 64'(slot.off_start);
  assign win_e    = base_q + 64'(slot.off_end);
  assign late     = in_global_time > win_e;
  assign lead_ok  = (in_global_time + 64'(LEAD)) >= win_s;
  assign act_late = in_global_time > we_q;
  // A shrunk slot count that leaves the index past the end wraps like end-of-list.
  assign last     = (cfg_num == '0) || ({1'b0, idx_q} >= (cfg_num - (AW+1)'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      miss_q  <= '0;
      wr_q    <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      port_q  <= '0;
      buf_q   <= '0;
      flow_q  <= '0;
      len_q   <= '0;
      ws_q    <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      miss_q  <= miss_d;
      wr_q    <= wr_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      port_q  <= port_d;
      buf_q   <= buf_d;
      flow_q  <= flow_d;
      len_q   <= len_d;
      ws_q    <= ws_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    miss_d  = miss_q;
    wr_d    = 1'b0;
    flag_d  = flag_q;
    port_d  = port_q;
    buf_d   = buf_q;
    flow_d  = flow_q;
    len_d   = len_q;
    ws_d    = ws_q;
    we_d    = we_q;

    case (state_q)
      ST_IDLE: begin
        flag_d = 1'b0;
        if (sched_en && (cfg_num != '0)) begin
          state_d = ST_WAIT_RDY;
          base_d  = cfg_base;
          idx_d   = '0;
        end
      end
      ST_WAIT_RDY: begin
        if (late) begin
          miss_d  = sat_inc(miss_q);
          state_d = ST_ADVANCE;
        end else if (in_table_rdy) begin
          state_d = ST_WAIT_LEAD;
        end
      end
      ST_WAIT_LEAD: begin
        if (late) begin
          miss_d  = sat_inc(miss_q);
          state_d = ST_ADVANCE;
        end else if (lead_ok) begin
          // Load the payload on entry so the strobe cycle carries valid data.
          state_d = ST_ISSUE;
          wr_d    = 1'b1;
          port_d  = slot.port;
          buf_d   = slot.buffer;
          flow_d  = slot.flow_id;
          len_d   = slot.tt_length;
          ws_d    = win_s;
          we_d    = win_e;
        end
      end
      ST_ISSUE: begin
        flag_d  = 1'b1;
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (in_tt_flag_clear) begin
          flag_d  = 1'b0;
          state_d = ST_ADVANCE;
        end else if (act_late) begin
          flag_d  = 1'b0;
          miss_d  = sat_inc(miss_q);
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        state_d = ST_WAIT_RDY;
        if (last) begin
          idx_d  = '0;
          base_d = base_q + 64'(cfg_period);
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!sched_en) begin
      state_d = ST_IDLE;
      wr_d    = 1'b0;
      flag_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign out_table_wr      = wr_q;
  assign out_port_number   = port_q;
  assign out_buffer_number = buf_q;
  assign out_window_start  = ws_q;
  assign out_window_end    = we_q;
  assign out_flow_id       = flow_q;
  assign out_tt_length     = len_q;
  assign out_tt_flag       = flag_q;
  assign out_cur_entry     = idx_q;
  assign out_miss_cnt      = miss_q;
  assign out_busy          = busy_q;

endmodule
